rc4_encrypt_fsm: RTL and testbench



---
 rtl/rc4_encrypt_fsm.sv | 293 +++++++++++++++++++++++++++++
 tb/tb_rc4_encrypt_fsm.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/rc4_encrypt_fsm.sv
// RC4 encryption engine: initialises and key-shuffles S, then XORs the keystream onto a plaintext ROM.
// Optional plaintext character-class checking is built when PLAINTEXT_CHECK_EN is defined.
module rc4_encrypt_fsm #(
    parameter int MESSAGE_LENGTH = 32,
    parameter int KEY_LENGTH     = 3
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [23:0] secret_key,
    input  logic [7:0]  q_s,
    input  logic [7:0]  q_p,
    output logic [7:0]  address_s,
    output logic [7:0]  data_s,
    output logic        wren_s,
    output logic [4:0]  address_p,
    output logic [4:0]  address_c,
    output logic [7:0]  data_c,
    output logic        wren_c,
    output logic        busy,
    output logic        done,
    output logic        plaintext_err
);

    localparam logic [4:0] K_LAST = 5'(MESSAGE_LENGTH - 1);
    localparam logic [7:0] KEY_LEN = 8'(KEY_LENGTH);

    typedef enum logic [4:0] {
        ST_IDLE,
        ST_INIT_S,
        ST_SH_RD_I, ST_SH_WAIT_I, ST_SH_LAT_I,
        ST_SH_RD_J, ST_SH_WAIT_J, ST_SH_LAT_J,
        ST_SH_WR_J, ST_SH_WR_I,  ST_SH_NEXT,
        ST_PG_RD_I, ST_PG_WAIT_I, ST_PG_LAT_I,
        ST_PG_RD_J, ST_PG_WAIT_J, ST_PG_LAT_J,
        ST_PG_WR_J, ST_PG_WR_I,
        ST_PG_RD_F, ST_PG_WAIT_F, ST_PG_LAT_F,
        ST_PG_NEXT,
        ST_DONE
    } state_t;

    state_t      state_r, state_nxt_s;
    logic [7:0]  i_r, i_nxt_s;
    logic [7:0]  j_r, j_nxt_s;
    logic [4:0]  k_r, k_nxt_s;
    logic [23:0] key_r, key_nxt_s;
    logic [7:0]  si_r, si_nxt_s;
    logic [7:0]  sj_r, sj_nxt_s;
    logic [7:0]  address_s_r, address_s_nxt_s;
    logic [7:0]  data_s_r, data_s_nxt_s;
    logic        wren_s_r, wren_s_nxt_s;
    logic [4:0]  address_p_r, address_p_nxt_s;
    logic [4:0]  address_c_r, address_c_nxt_s;
    logic [7:0]  data_c_r, data_c_nxt_s;
    logic        wren_c_r, wren_c_nxt_s;
    logic        busy_r, busy_nxt_s;
    logic        done_r, done_nxt_s;
    logic [7:0]  key_byte_s;

`ifdef PLAINTEXT_CHECK_EN
    logic        perr_r, perr_nxt_s;

    // Accepted plaintext alphabet: lowercase letters and space.
    function automatic logic is_text_byte(input logic [7:0] b);
        return ((b >= 8'd97) && (b <= 8'd122)) || (b == 8'd32);
    endfunction
`endif

    // Key byte cycles high-to-low through the 24-bit key as i advances.
    always_comb begin
        case (i_r % KEY_LEN)
            8'd0:    key_byte_s = key_r[23:16];
            8'd1:    key_byte_s = key_r[15:8];
            default: key_byte_s = key_r[7:0];
        endcase
    end

    // Next-state and next-output logic; memory strobes default low, addresses hold.
    always_comb begin
        state_nxt_s     = state_r;
        i_nxt_s         = i_r;
        j_nxt_s         = j_r;
        k_nxt_s         = k_r;
        key_nxt_s       = key_r;
        si_nxt_s        = si_r;
        sj_nxt_s        = sj_r;
        address_s_nxt_s = address_s_r;
        data_s_nxt_s    = data_s_r;
        wren_s_nxt_s    = 1'b0;
        address_p_nxt_s = address_p_r;
        address_c_nxt_s = address_c_r;
        data_c_nxt_s    = data_c_r;
        wren_c_nxt_s    = 1'b0;
        busy_nxt_s      = busy_r;
        done_nxt_s      = done_r;
`ifdef PLAINTEXT_CHECK_EN
        perr_nxt_s      = perr_r;
`endif
        case (state_r)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    key_nxt_s   = secret_key;
                    done_nxt_s  = 1'b0;
                    busy_nxt_s  = 1'b1;
                    i_nxt_s     = 8'd0;
                    state_nxt_s = ST_INIT_S;
`ifdef PLAINTEXT_CHECK_EN
                    perr_nxt_s  = 1'b0;
`endif
                end else begin
                    busy_nxt_s  = 1'b0;
                end
            end
            ST_INIT_S: begin
                address_s_nxt_s = i_r;
                data_s_nxt_s    = i_r;
                wren_s_nxt_s    = 1'b1;
                i_nxt_s         = i_r + 8'd1;
                if (i_r == 8'd255) begin
                    j_nxt_s     = 8'd0;
                    state_nxt_s = ST_SH_RD_I;
                end else begin
                    state_nxt_s = ST_INIT_S;
                end
            end
            ST_SH_RD_I: begin
                address_s_nxt_s = i_r;
                state_nxt_s     = ST_SH_WAIT_I;
            end
            ST_SH_WAIT_I: state_nxt_s = ST_SH_LAT_I;
            ST_SH_LAT_I: begin
                si_nxt_s    = q_s;
                j_nxt_s     = j_r + q_s + key_byte_s;
                state_nxt_s = ST_SH_RD_J;
            end
            ST_SH_RD_J: begin
                address_s_nxt_s = j_r;
                state_nxt_s     = ST_SH_WAIT_J;
            end
            ST_SH_WAIT_J: state_nxt_s = ST_SH_LAT_J;
            ST_SH_LAT_J: begin
                sj_nxt_s    = q_s;
                state_nxt_s = ST_SH_WR_J;
            end
            ST_SH_WR_J: begin
                address_s_nxt_s = j_r;
                data_s_nxt_s    = si_r;
                wren_s_nxt_s    = 1'b1;
                state_nxt_s     = ST_SH_WR_I;
            end
            ST_SH_WR_I: begin
                address_s_nxt_s = i_r;
                data_s_nxt_s    = sj_r;
                wren_s_nxt_s    = 1'b1;
                state_nxt_s     = ST_SH_NEXT;
            end
            ST_SH_NEXT: begin
                if (i_r != 8'd255) begin
                    i_nxt_s     = i_r + 8'd1;
                    state_nxt_s = ST_SH_RD_I;
                end else begin
                    i_nxt_s     = 8'd1;
                    j_nxt_s     = 8'd0;
                    k_nxt_s     = 5'd0;
                    state_nxt_s = ST_PG_RD_I;
                end
            end
            ST_PG_RD_I: begin
                address_s_nxt_s = i_r;
                state_nxt_s     = ST_PG_WAIT_I;
            end
            ST_PG_WAIT_I: state_nxt_s = ST_PG_LAT_I;
            ST_PG_LAT_I: begin
                si_nxt_s    = q_s;
                j_nxt_s     = j_r + q_s;
                state_nxt_s = ST_PG_RD_J;
            end
            ST_PG_RD_J: begin
                address_s_nxt_s = j_r;
                state_nxt_s     = ST_PG_WAIT_J;
            end
            ST_PG_WAIT_J: state_nxt_s = ST_PG_LAT_J;
            ST_PG_LAT_J: begin
                sj_nxt_s    = q_s;
                state_nxt_s = ST_PG_WR_J;
            end
            ST_PG_WR_J: begin
                address_s_nxt_s = j_r;
                data_s_nxt_s    = si_r;
                wren_s_nxt_s    = 1'b1;
                state_nxt_s     = ST_PG_WR_I;
            end
            ST_PG_WR_I: begin
                address_s_nxt_s = i_r;
                data_s_nxt_s    = sj_r;
                wren_s_nxt_s    = 1'b1;
                state_nxt_s     = ST_PG_RD_F;
            end
            ST_PG_RD_F: begin
                address_s_nxt_s = si_r + sj_r;
                address_p_nxt_s = k_r;
                state_nxt_s     = ST_PG_WAIT_F;
            end
            ST_PG_WAIT_F: state_nxt_s = ST_PG_LAT_F;
            ST_PG_LAT_F: begin
                address_c_nxt_s = k_r;
                data_c_nxt_s    = q_s ^ q_p;
                wren_c_nxt_s    = 1'b1;
                state_nxt_s     = ST_PG_NEXT;
`ifdef PLAINTEXT_CHECK_EN
                if (!is_text_byte(q_p)) begin
                    perr_nxt_s = 1'b1;
                end else begin
                    perr_nxt_s = perr_r;
                end
`endif
            end
            ST_PG_NEXT: begin
                if (k_r < K_LAST) begin
                    k_nxt_s     = k_r + 5'd1;
                    i_nxt_s     = i_r + 8'd1;
                    state_nxt_s = ST_PG_RD_I;
                end else begin
                    busy_nxt_s  = 1'b0;
                    done_nxt_s  = 1'b1;
                    state_nxt_s = ST_DONE;
                end
            end
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // State, datapath and registered-output flops; reset aborts any run in progress.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ST_IDLE;
            i_r         <= 8'd0;
            j_r         <= 8'd0;
            k_r         <= 5'd0;
            key_r       <= 24'd0;
            si_r        <= 8'd0;
            sj_r        <= 8'd0;
            address_s_r <= 8'd0;
            data_s_r    <= 8'd0;
            wren_s_r    <= 1'b0;
            address_p_r <= 5'd0;
            address_c_r <= 5'd0;
            data_c_r    <= 8'd0;
            wren_c_r    <= 1'b0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
`ifdef PLAINTEXT_CHECK_EN
            perr_r      <= 1'b0;
`endif
        end else begin
            state_r     <= state_nxt_s;
            i_r         <= i_nxt_s;
            j_r         <= j_nxt_s;
            k_r         <= k_nxt_s;
            key_r       <= key_nxt_s;
            si_r        <= si_nxt_s;
            sj_r        <= sj_nxt_s;
            address_s_r <= address_s_nxt_s;
            data_s_r    <= data_s_nxt_s;
            wren_s_r    <= wren_s_nxt_s;
            address_p_r <= address_p_nxt_s;
            address_c_r <= address_c_nxt_s;
            data_c_r    <= data_c_nxt_s;
            wren_c_r    <= wren_c_nxt_s;
            busy_r      <= busy_nxt_s;
            done_r      <= done_nxt_s;
`ifdef PLAINTEXT_CHECK_EN
            perr_r      <= perr_nxt_s;
`endif
        end
    end

    assign address_s = address_s_r;
    assign data_s    = data_s_r;
    assign wren_s    = wren_s_r;
    assign address_p = address_p_r;
    assign address_c = address_c_r;
    assign data_c    = data_c_r;
    assign wren_c    = wren_c_r;
    assign busy      = busy_r;
    assign done      = done_r;
`ifdef PLAINTEXT_CHECK_EN
    assign plaintext_err = perr_r;
`else
    assign plaintext_err = 1'b0;
`endif

endmodule

// File: tb/tb_rc4_encrypt_fsm.sv
// Scoreboard bench for rc4_encrypt_fsm: behavioural S/ROM/RAM models and a software RC4 reference.
module tb_rc4_encrypt_fsm;

    localparam int MSG_LEN = 32;
    localparam int LATENCY = 256 + 256 * 9 + MSG_LEN * 12;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [23:0] secret_key = 24'd0;
    logic [7:0]  q_s, q_p;
    logic [7:0]  address_s, data_s;
    logic        wren_s;
    logic [4:0]  address_p, address_c;
    logic [7:0]  data_c;
    logic        wren_c, busy, done, plaintext_err;

    rc4_encrypt_fsm #(.MESSAGE_LENGTH(MSG_LEN), .KEY_LENGTH(3)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .secret_key(secret_key),
        .q_s(q_s), .q_p(q_p),
        .address_s(address_s), .data_s(data_s), .wren_s(wren_s),
        .address_p(address_p), .address_c(address_c), .data_c(data_c), .wren_c(wren_c),
        .busy(busy), .done(done), .plaintext_err(plaintext_err)
    );

    always #5 clk = ~clk;

    logic [7:0] s_mem [256];
    logic [7:0] p_rom [MSG_LEN];
    logic [7:0] c_ram [MSG_LEN];
    logic [7:0] orig_p [MSG_LEN];
    logic [7:0] gold_c [MSG_LEN];

    typedef struct packed {
        logic [4:0] addr;
        logic [7:0] data;
    } sb_entry_t;
    sb_entry_t sb_q [$];

    int n_vec = 0;
    int n_err = 0;

    task automatic check_val(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    // Synchronous memories: address registered at the edge, data one cycle later.
    always @(posedge clk) begin
        if (wren_s) s_mem[address_s] <= data_s;
        q_s <= s_mem[address_s];
        q_p <= p_rom[address_p];
    end

    // Ciphertext writes are compared against the scoreboard away from the active edge.
    always @(negedge clk) begin
        if (rst_n && wren_c) begin
            sb_entry_t e;
            c_ram[address_c] = data_c;
            if (sb_q.size() == 0) begin
                check_val("unexpected_ct_write", {59'd0, address_c}, 64'hFFFF);
            end else begin
                e = sb_q.pop_front();
                check_val("ct_addr", {59'd0, address_c}, {59'd0, e.addr});
                check_val("ct_data", {56'd0, data_c}, {56'd0, e.data});
            end
        end
    end

    // Plain software RC4 over the current plaintext ROM; pushes expected writes.
    task automatic push_model(input logic [23:0] key);
        logic [7:0] s [256];
        logic [7:0] kb [3];
        logic [7:0] i, j, t;
        kb[0] = key[23:16];
        kb[1] = key[15:8];
        kb[2] = key[7:0];
        for (int n = 0; n < 256; n++) s[n] = 8'(n);
        j = 8'd0;
        for (int n = 0; n < 256; n++) begin
            j = j + s[n] + kb[n % 3];
            t = s[n]; s[n] = s[j]; s[j] = t;
        end
        i = 8'd0;
        j = 8'd0;
        for (int n = 0; n < MSG_LEN; n++) begin
            i = i + 8'd1;
            j = j + s[i];
            t = s[i]; s[i] = s[j]; s[j] = t;
            t = s[i] + s[j];
            sb_q.push_back({5'(n), s[t] ^ p_rom[n]});
        end
    endtask

    task automatic push_plain();
        for (int n = 0; n < MSG_LEN; n++) sb_q.push_back({5'(n), orig_p[n]});
    endtask

    // One start pulse, then cycle-by-cycle observation until done or a cycle budget expires.
    task automatic run_msg(input logic [23:0] key, input bit chk_init, input bit extra_starts,
                           output int perr_cyc);
        int init_bad, both_bad, busy_bad, done_cyc;
        init_bad = 0; both_bad = 0; busy_bad = 0; done_cyc = -1; perr_cyc = -1;
        secret_key = key;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int cyc = 1; cyc <= LATENCY + 200; cyc++) begin
            @(posedge clk); #1;
            if (extra_starts && (cyc == 10 || cyc == 1000)) begin
                start = 1'b1;
                secret_key = 24'hABCDEF;
            end else begin
                start = 1'b0;
            end
            if (chk_init && cyc <= 256) begin
                if (!(wren_s && address_s == 8'(cyc - 1) && data_s == 8'(cyc - 1))) init_bad++;
            end
            if (chk_init && cyc == 257)
                check_val("first_sh_rd", {55'd0, wren_s, address_s}, 64'd0);
            if (wren_s && wren_c) both_bad++;
            if (plaintext_err && perr_cyc < 0) perr_cyc = cyc;
            if (done) begin
                done_cyc = cyc;
                break;
            end else if (!busy) begin
                busy_bad++;
            end
        end
        start = 1'b0;
        secret_key = key;
        if (chk_init) check_val("init_s_writes", 64'(init_bad), 64'd0);
        check_val("done_latency", 64'(done_cyc), 64'(LATENCY));
        check_val("busy_held", 64'(busy_bad), 64'd0);
        check_val("wren_exclusive", 64'(both_bad), 64'd0);
        check_val("busy_after_done", {63'd0, busy}, 64'd0);
        check_val("sb_drained", 64'(sb_q.size()), 64'd0);
        sb_q.delete();
    endtask

    initial begin
        string msg;
        int perr_cyc;
        msg = "the quick brown fox jumps over t";
        for (int n = 0; n < MSG_LEN; n++) begin
            orig_p[n] = msg[n];
            p_rom[n]  = msg[n];
        end
        repeat (3) @(posedge clk);
        #1;
        check_val("reset_outputs",
                  {25'd0, address_s, data_s, wren_s, address_p, address_c, data_c, wren_c,
                   busy, done, plaintext_err}, 64'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Zero key with INIT_S sequence check.
        push_model(24'h000000);
        run_msg(24'h000000, 1'b1, 1'b0, perr_cyc);

        // Golden vector.
        push_model(24'h000018);
        run_msg(24'h000018, 1'b0, 1'b0, perr_cyc);
        check_val("plaintext_err_clean", {63'd0, plaintext_err}, 64'd0);
        for (int n = 0; n < MSG_LEN; n++) gold_c[n] = c_ram[n];

        // Involution: ciphertext as plaintext returns the original text.
        for (int n = 0; n < MSG_LEN; n++) p_rom[n] = gold_c[n];
        push_plain();
        run_msg(24'h000018, 1'b0, 1'b0, perr_cyc);
        for (int n = 0; n < MSG_LEN; n++) p_rom[n] = orig_p[n];

        // Starts while busy must be ignored.
        push_model(24'h000018);
        run_msg(24'h000018, 1'b0, 1'b1, perr_cyc);

        // Reset in the middle of SHUFFLE.
        secret_key = 24'h000018;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (1499) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check_val("midrun_reset_outputs",
                  {25'd0, address_s, data_s, wren_s, address_p, address_c, data_c, wren_c,
                   busy, done, plaintext_err}, 64'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        push_model(24'h000018);
        run_msg(24'h000018, 1'b0, 1'b0, perr_cyc);
        for (int n = 0; n < MSG_LEN; n++)
            if (c_ram[n] !== gold_c[n]) check_val("post_reset_golden", {56'd0, c_ram[n]}, {56'd0, gold_c[n]});

        // Non-text plaintext byte at position 5.
        p_rom[5] = 8'h41;
        push_model(24'h000018);
        run_msg(24'h000018, 1'b0, 1'b0, perr_cyc);
`ifdef PLAINTEXT_CHECK_EN
        check_val("perr_rise_cycle", 64'(perr_cyc), 64'(256 + 256 * 9 + 5 * 12 + 11));
        check_val("perr_sticky", {63'd0, plaintext_err}, 64'd1);
`else
        check_val("perr_disabled", 64'(perr_cyc), 64'hFFFF_FFFF_FFFF_FFFF);
        check_val("perr_tied_low", {63'd0, plaintext_err}, 64'd0);
`endif
        p_rom[5] = orig_p[5];

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
